// File: rtl/ds_mem_responder.sv
// DS-format (LD/STD) doubleword memory responder with a fixed wait-state latency.
// Optional macro DS_MEM_ALIGN_CHECK_EN also reports misaligned effective addresses as errors.
module ds_mem_responder #(
  parameter int DEPTH_LOG2 = 6,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [63:0] base,
  input  logic [13:0] ds,
  input  logic [63:0] wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {IDLE, WAIT, EXEC, RESP} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        store_q, store_d;
  logic [63:0] ea_q, ea_d;
  logic [63:0] wdata_q, wdata_d;
  logic        req_ready_q, req_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [63:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;

  logic [63:0]           mem [DEPTH];
  logic [63:0]           ea_in;
  logic [DEPTH_LOG2-1:0] idx;
  logic                  err;
  logic                  mem_we;

  // DS is a word-scaled displacement: append two zero bits, then sign-extend.
  assign ea_in = base + {{48{ds[13]}}, ds, 2'b00};
  assign idx   = ea_q[DEPTH_LOG2+2:3];

`ifdef DS_MEM_ALIGN_CHECK_EN
  assign err = (|ea_q[63:DEPTH_LOG2+3]) | (|ea_q[2:0]);
`else
  logic unused_ea_lsb;
  assign err           = |ea_q[63:DEPTH_LOG2+3];
  assign unused_ea_lsb = ^ea_q[2:0];
`endif

  assign mem_we = (state_q == EXEC) && store_q && !err;

  // NOTE: every variable gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    store_d     = store_q;
    ea_d        = ea_q;
    wdata_d     = wdata_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          store_d     = req_store;
          ea_d        = ea_in;
          wdata_d     = wdata;
          req_ready_d = 1'b0;
          if (LATENCY > 0) begin
            state_d = WAIT;
            cnt_d   = 4'(LATENCY);
          end else begin
            state_d = EXEC;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = EXEC;
      end
      EXEC: begin
        state_d     = RESP;
        rsp_valid_d = 1'b1;
        rsp_err_d   = err;
        rsp_rdata_d = (store_q || err) ? 64'd0 : mem[idx];
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      store_q     <= 1'b0;
      ea_q        <= 64'd0;
      wdata_q     <= 64'd0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 64'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      store_q     <= store_d;
      ea_q        <= ea_d;
      wdata_q     <= wdata_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // NOTE: the array has no reset so contents survive rst_n; an interrupted store is dropped by the FSM reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[idx] <= wdata_q;
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_ds_mem_responder.sv
// Directed self-checking bench for ds_mem_responder (DEPTH_LOG2=6, LATENCY=2).
// Alignment expectations follow whether DS_MEM_ALIGN_CHECK_EN is defined for the build.
module tb_ds_mem_responder;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_store;
  logic [63:0] base, wdata;
  logic [13:0] ds;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [63:0] rsp_rdata;

  int checks   = 0;
  int failures = 0;

  ds_mem_responder #(.DEPTH_LOG2(6), .LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .base(base), .ds(ds), .wdata(wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Present a request and return at the falling edge after it was accepted, with inputs scrambled.
  task automatic issue(input logic st, input logic [63:0] b, input logic [13:0] d, input logic [63:0] w);
    int n = 0;
    @(negedge clk);
    req_valid = 1'b1; req_store = st; base = b; ds = d; wdata = w;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("accept_timeout", 64'(n), 64'd0);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_store = ~st; base = ~b; ds = ~d; wdata = ~w;
  endtask

  task automatic await_rsp(input string tag, output logic [63:0] rd, output logic er);
    int n = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end while (!rsp_valid && n < 50);
    check({tag, "_lat"}, 64'(n), 64'(LAT + 1));
    rd = rsp_rdata;
    er = rsp_err;
  endtask

  task automatic finish_rsp(input string tag);
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    check({tag, "_vld_low"}, 64'(rsp_valid), 64'd0);
    check({tag, "_rdy_high"}, 64'(req_ready), 64'd1);
  endtask

  task automatic xact(input string tag, input logic st, input logic [63:0] b, input logic [13:0] d,
                      input logic [63:0] w, input logic [63:0] exp_rd, input logic exp_err);
    logic [63:0] rd;
    logic        er;
    issue(st, b, d, w);
    await_rsp(tag, rd, er);
    check({tag, "_rdata"}, rd, exp_rd);
    check({tag, "_err"}, 64'(er), 64'(exp_err));
    finish_rsp(tag);
  endtask

  initial begin
    logic [63:0] rd;
    logic        er;
    rst_n = 1'b0; req_valid = 1'b0; req_store = 1'b0; base = '0; ds = '0; wdata = '0; rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_rdata", rsp_rdata, 64'd0);
    check("rst_rsp_err", 64'(rsp_err), 64'd0);
    rst_n = 1'b1;

    // Basic store/load: EA = 0x20 + 8 = 0x28, index 5.
    xact("std_basic", 1'b1, 64'h20, 14'd2, 64'hDEADBEEF_01234567, 64'd0, 1'b0);
    xact("ld_basic", 1'b0, 64'h20, 14'd2, 64'd0, 64'hDEADBEEF_01234567, 1'b0);

    // Negative displacement: 0x40 - 8 = 0x38, same as 0x30 + 8.
    xact("std_neg", 1'b1, 64'h40, 14'h3FFE, 64'hCAFEF00D_55AA33CC, 64'd0, 1'b0);
    xact("ld_neg", 1'b0, 64'h30, 14'd2, 64'd0, 64'hCAFEF00D_55AA33CC, 1'b0);

    // Out of range: 0x200 aliases index 0 in its low bits, so index 0 must stay intact.
    xact("std_idx0", 1'b1, 64'h0, 14'd0, 64'hA5A5_A5A5_5A5A_5A5A, 64'd0, 1'b0);
    xact("ld_oor", 1'b0, 64'h200, 14'd0, 64'd0, 64'd0, 1'b1);
    xact("std_oor", 1'b1, 64'h200, 14'd0, 64'hFFFF_0000_FFFF_0000, 64'd0, 1'b1);
    xact("ld_idx0", 1'b0, 64'h0, 14'd0, 64'd0, 64'hA5A5_A5A5_5A5A_5A5A, 1'b0);
    xact("ld_top_bit", 1'b0, 64'h8000_0000_0000_0000, 14'd0, 64'd0, 64'd0, 1'b1);
    // Address wraps modulo 2^64 back to index 0.
    xact("ld_wrap", 1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 14'd2, 64'd0, 64'hA5A5_A5A5_5A5A_5A5A, 1'b0);

    // Misaligned access to index 4.
    xact("std_idx4", 1'b1, 64'h20, 14'd0, 64'h4444_3333_2222_1111, 64'd0, 1'b0);
`ifdef DS_MEM_ALIGN_CHECK_EN
    xact("ld_misalign", 1'b0, 64'h24, 14'd0, 64'd0, 64'd0, 1'b1);
`else
    xact("ld_misalign", 1'b0, 64'h24, 14'd0, 64'd0, 64'h4444_3333_2222_1111, 1'b0);
`endif

    // Backpressure with a second request pending.
    issue(1'b0, 64'h28, 14'd0, 64'd0);
    await_rsp("bp_first", rd, er);
    check("bp_first_rdata", rd, 64'hDEADBEEF_01234567);
    req_valid = 1'b1; req_store = 1'b0; base = 64'h38; ds = 14'd0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("bp_vld_%0d", i), 64'(rsp_valid), 64'd1);
      check($sformatf("bp_rdata_%0d", i), rsp_rdata, 64'hDEADBEEF_01234567);
      check($sformatf("bp_rdy_%0d", i), 64'(req_ready), 64'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    check("bp_hs_vld_low", 64'(rsp_valid), 64'd0);
    check("bp_hs_rdy_high", 64'(req_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    check("bp_second_accepted", 64'(req_ready), 64'd0);
    req_valid = 1'b0; base = '1;
    await_rsp("bp_second", rd, er);
    check("bp_second_rdata", rd, 64'hCAFEF00D_55AA33CC);
    check("bp_second_err", 64'(er), 64'd0);
    finish_rsp("bp_second");

    // Reset during the wait of a store to index 3: the store is dropped.
    xact("std_idx3", 1'b1, 64'h18, 14'd0, 64'h11, 64'd0, 1'b0);
    xact("ld_idx3_pre", 1'b0, 64'h18, 14'd0, 64'd0, 64'h11, 1'b0);
    issue(1'b1, 64'h18, 14'd0, 64'h99);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_req_ready", 64'(req_ready), 64'd1);
    check("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("midrst_rsp_rdata", rsp_rdata, 64'd0);
    check("midrst_rsp_err", 64'(rsp_err), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    xact("ld_idx3_post", 1'b0, 64'h18, 14'd0, 64'd0, 64'h11, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ds_mem_responder.md
# ds_mem_responder

Data-memory responder for the uPower DS-format load/store path (LD / STD). Accepts one doubleword request at a time from the DS-format datapath over a valid/ready request channel. Computes the effective address from base register data and the DS displacement, then performs the read or write after a fixed wait-state latency. Returns the result on a valid/ready response channel.

## Interface
- `DEPTH_LOG2`, 6, memory holds 2^DEPTH_LOG2 doublewords of 64 bits
- `LATENCY`, 2, wait-state cycles between request accept and response (0..15)

- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `req_valid`  in  1  request present
- `req_ready`  out  1  responder can accept a request
- `req_store`  in  1  1 = STD (write), 0 = LD (read)
- `base`  in  64  contents of register ra
- `ds`  in  14  DS displacement field, signed
- `wdata`  in  64  contents of register rt (stores only)
- `rsp_valid`  out  1  response present
- `rsp_ready`  in  1  requester accepts response
- `rsp_rdata`  out  64  load data; 0 for stores and errors
- `rsp_err`  out  1  address error; no memory access was performed

## Operation
- EA = base + sign_extend({ds, 2'b00}) to 64 bits; modulo-2^64 wrap.
- Index = EA[DEPTH_LOG2+2:3].
- Out-of-range error: any bit of EA[63:DEPTH_LOG2+3] is set.
- Request capture: on the accept edge (req_valid & req_ready), latch req_store, EA and wdata. Later input changes are ignored.
- FSM states:
  - IDLE: req_ready=1, rsp_valid=0. On accept: go to WAIT with cnt=LATENCY if LATENCY>0; otherwise go to EXEC.
  - WAIT: cnt decrements each cycle. When cnt reaches 1, next state is EXEC.
  - EXEC: single cycle. Performs the memory write (store, no error) or registers the read data (load, no error). Sets rsp_err and rsp_rdata. Next state is RESP.
  - RESP: rsp_valid=1. rsp_rdata and rsp_err stay stable until rsp_valid & rsp_ready, then go to IDLE.
- req_ready=0 in all states except IDLE. No request pipelining.
- Error cases: memory is not written and rsp_rdata=0.
- Memory array has no reset. Contents persist across rst_n.
- Reset asserted mid-operation: the FSM returns to IDLE immediately. A store not yet in EXEC is dropped. A store that already completed EXEC stays committed.

## Timing
- Reset values: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, state=IDLE, cnt=0.
- Accept at edge N: EXEC occupies cycle N+LATENCY+1, and rsp_valid rises after edge N+LATENCY+1.
  - LATENCY=2: rsp_valid is high from edge N+3.
- Store data is visible to a load accepted on any later edge.
- Handshake completes at edge M (rsp_valid & rsp_ready). req_ready=1 from edge M, so the next accept is no earlier than edge M+1.
- Minimum request period with rsp_ready tied high: LATENCY+3 cycles.
- rsp_ready high outside RESP is ignored.
- req_valid high while req_ready=0 is ignored; the requester must hold it.

## Configuration
- `DS_MEM_ALIGN_CHECK_EN` defined: EA[2:0]≠0 sets rsp_err=1. No write is performed and rsp_rdata=0. Errors are the OR of misalignment and out-of-range.
- `DS_MEM_ALIGN_CHECK_EN` undefined: EA[2:0] is ignored; only out-of-range errors are reported.

## Test plan
- Reset, then STD with base=0x20, ds=2, wdata=0xDEADBEEF_01234567, followed by LD with the same base and ds → rsp_err=0 for both. The load returns rsp_rdata=0xDEADBEEF_01234567. Both rsp_valid edges occur 3 cycles after accept (LATENCY=2).
- Negative displacement: STD base=0x40, ds=-2 (EA=0x38, index 7), then LD base=0x30, ds=2 → the load returns the stored value.
- Backpressure: rsp_ready held low 5 cycles in RESP → rsp_valid and rsp_rdata stay stable and req_ready stays 0. A new req_valid during this time is not accepted until 1 cycle after the handshake.
- Out-of-range: LD base=0x200, ds=0 (DEPTH_LOG2=6) → rsp_err=1, rsp_rdata=0. STD to the same address → rsp_err=1 and memory is unchanged, checked by reading index 0.
- With the macro defined: LD base=0x24, ds=0 → rsp_err=1. Same access without the macro → reads index 4, rsp_err=0.
- rst_n pulsed low 1 cycle after accepting an STD to index 3 (holding 0x11) → outputs return to reset values at once and index 3 still reads 0x11.
